// File: rtl/pwm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pwm_ctrl_pkg
//
// Shared types and default constants for the PWM duty sequencer.
//   - pwm_state_e : controller state (IDLE, SOFT, RUN, RAMP)
//   - pwm_dir_e   : pending manual step direction
//   - PERIOD, DUTY_W, DUTY_INIT, RAMP_DIV : default configuration
//   - clamp_to_period() : clamps a host target into the legal duty range
// ---------------------------------------------------------------------------
package pwm_ctrl_pkg;

    // Default configuration; the top module exposes each as a parameter.
    localparam int unsigned PERIOD    = 10;
    localparam int unsigned DUTY_W    = 4;
    localparam int unsigned DUTY_INIT = 5;
    localparam int unsigned RAMP_DIV  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOFT = 2'd1,
        ST_RUN  = 2'd2,
        ST_RAMP = 2'd3
    } pwm_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_INC  = 2'd1,
        DIR_DEC  = 2'd2
    } pwm_dir_e;

    // Host targets beyond the period would mean "more than 100%"; they are
    // limited to the period instead of being rejected.
    function automatic int unsigned clamp_to_period(input int unsigned value,
                                                    input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm_ramp_divider.sv
// ---------------------------------------------------------------------------
// pwm_ramp_divider
//
// Counts PWM period boundaries and emits one step pulse every RAMP_DIV of
// them. Used to pace the soft-start and target ramps.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   clr          in   hold the count at zero (idle/run states, ramp entry)
//   period_start in   one-cycle pulse at each PWM period wrap
//   step         out  high in the cycle of the RAMP_DIV-th counted pulse
// ---------------------------------------------------------------------------
module pwm_ramp_divider #(
    parameter int unsigned RAMP_DIV = pwm_ctrl_pkg::RAMP_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic period_start,
    output logic step
);

    // A divider of 1 still needs a one-bit counter that simply stays at zero.
    localparam int unsigned     CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over counting, wrap after the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (period_start) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign step = period_start && !clr && (cnt_q == CNT_LAST);

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_duty_sequencer
//
// Duty-cycle controller for one PWM channel. Chooses the duty value fed to
// the PWM comparator and changes it only at PWM period boundaries. Sources,
// highest priority first: the enable-driven soft-start ramp, a host target
// (valid/ready handshake, approached one step at a time), and single-step
// manual increase/decrease requests.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   en            in   channel enable (level); low forces duty to 0
//   period_start  in   pulse when the PWM counter wraps to 0
//   inc_req       in   manual request: duty + 1 at the next boundary
//   dec_req       in   manual request: duty - 1 at the next boundary
//   target_valid  in   host target offered
//   target_duty   in   host target (clamped to PERIOD)
//   target_ready  out  host target can be accepted (RUN only)
//   duty          out  current duty value
//   duty_update   out  pulse in the cycle duty takes a new value
//   busy          out  soft-start or target ramp in progress
//   req_dropped   out  pulse when a manual request is discarded
//
// Build option:
//   PWM_SOFT_START_EN defined   : enable ramps duty 0 -> DUTY_INIT (SOFT).
//   PWM_SOFT_START_EN undefined : enable goes straight to RUN and duty loads
//                                 DUTY_INIT at the first period boundary.
// ---------------------------------------------------------------------------
module pwm_duty_sequencer #(
    parameter int unsigned PERIOD    = pwm_ctrl_pkg::PERIOD,
    parameter int unsigned DUTY_W    = pwm_ctrl_pkg::DUTY_W,
    parameter int unsigned DUTY_INIT = pwm_ctrl_pkg::DUTY_INIT,
    parameter int unsigned RAMP_DIV  = pwm_ctrl_pkg::RAMP_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              period_start,
    input  logic              inc_req,
    input  logic              dec_req,
    input  logic              target_valid,
    input  logic [DUTY_W-1:0] target_duty,
    output logic              target_ready,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_update,
    output logic              busy,
    output logic              req_dropped
);

    import pwm_ctrl_pkg::*;

    localparam logic [DUTY_W-1:0] PERIOD_D    = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] DUTY_INIT_D = DUTY_W'(DUTY_INIT);

    pwm_state_e        state_q, state_d;
    pwm_dir_e          dir_q, dir_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic              duty_update_q, duty_update_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              dropped_q, dropped_d;

`ifndef PWM_SOFT_START_EN
    // Set on entry to RUN; the first boundary then loads DUTY_INIT.
    logic              init_q, init_d;
`endif

    logic              div_clr;
    logic              div_step;
    logic              accept;
    logic [DUTY_W-1:0] tgt_clamped;
    logic [DUTY_W-1:0] duty_plus;
    logic [DUTY_W-1:0] duty_minus;

    assign duty_plus   = duty_q + 1'b1;
    assign duty_minus  = duty_q - 1'b1;
    assign tgt_clamped = DUTY_W'(clamp_to_period(32'(target_duty), PERIOD));
    assign accept      = target_valid && ready_q;

    // The divider only runs while ramping; holding it clear in IDLE and RUN
    // means every SOFT/RAMP entry starts from a fresh count.
    assign div_clr = (state_q == ST_IDLE) || (state_q == ST_RUN);

    pwm_ramp_divider #(
        .RAMP_DIV(RAMP_DIV)
    ) u_ramp_divider (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (div_clr),
        .period_start(period_start),
        .step        (div_step)
    );

    // Next-state and next-output logic. Dropping the enable overrides every
    // state. In RUN an accepted target that differs from the current duty
    // takes precedence over a manual step due at the same boundary, and a
    // request arriving together with a boundary becomes the new pending step.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        duty_d    = duty_q;
        tgt_d     = tgt_q;
`ifndef PWM_SOFT_START_EN
        init_d    = init_q;
`endif
        dropped_d = (inc_req || dec_req) && (state_q != ST_RUN);

        if (!en) begin
            state_d = ST_IDLE;
            duty_d  = '0;
            dir_d   = DIR_NONE;
`ifndef PWM_SOFT_START_EN
            init_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef PWM_SOFT_START_EN
                    state_d = ST_SOFT;
`else
                    state_d = ST_RUN;
                    init_d  = 1'b1;
`endif
                end

`ifdef PWM_SOFT_START_EN
                ST_SOFT: begin
                    if (div_step) begin
                        duty_d = duty_plus;
                        if (duty_plus == DUTY_INIT_D) begin
                            state_d = ST_RUN;
                        end
                    end
                end
`endif

                ST_RUN: begin
                    if (accept && (tgt_clamped != duty_q)) begin
                        state_d = ST_RAMP;
                        tgt_d   = tgt_clamped;
                        dir_d   = DIR_NONE;
                    end else begin
                        if (period_start) begin
                            dir_d = DIR_NONE;
`ifndef PWM_SOFT_START_EN
                            if (init_q) begin
                                duty_d = DUTY_INIT_D;
                                init_d = 1'b0;
                            end else
`endif
                            if ((dir_q == DIR_INC) && (duty_q != PERIOD_D)) begin
                                duty_d = duty_plus;
                            end else if ((dir_q == DIR_DEC) && (duty_q != '0)) begin
                                duty_d = duty_minus;
                            end
                        end
                        if (inc_req && dec_req) begin
                            dir_d = DIR_NONE;
                        end else if (inc_req) begin
                            dir_d = DIR_INC;
                        end else if (dec_req) begin
                            dir_d = DIR_DEC;
                        end
                    end
                end

                ST_RAMP: begin
                    if (div_step) begin
                        duty_d = (tgt_q > duty_q) ? duty_plus : duty_minus;
                        if (duty_d == tgt_q) begin
                            state_d = ST_RUN;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                    dir_d   = DIR_NONE;
                end
            endcase
        end

        duty_update_d = (duty_d != duty_q);
        busy_d        = (state_d == ST_SOFT) || (state_d == ST_RAMP);
`ifdef PWM_SOFT_START_EN
        ready_d       = (state_d == ST_RUN);
`else
        ready_d       = (state_d == ST_RUN) && !init_d;
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dir_q         <= DIR_NONE;
            duty_q        <= '0;
            tgt_q         <= '0;
            duty_update_q <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            duty_q        <= duty_d;
            tgt_q         <= tgt_d;
            duty_update_q <= duty_update_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            dropped_q     <= dropped_d;
        end
    end

`ifndef PWM_SOFT_START_EN
    // Pending first-boundary load of DUTY_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= init_d;
        end
    end
`endif

    assign duty         = duty_q;
    assign duty_update  = duty_update_q;
    assign busy         = busy_q;
    assign target_ready = ready_q;
    assign req_dropped  = dropped_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_sequencer
//
// Self-checking bench for pwm_duty_sequencer. A behavioural model of the
// channel predicts every duty change and every dropped request; predictions
// are queued with the clock edge they belong to and a monitor compares them
// with the DUT's duty_update / req_dropped pulses. Honours PWM_SOFT_START_EN.
// ---------------------------------------------------------------------------
module tb_pwm_duty_sequencer;

    localparam int PERIOD    = 10;
    localparam int DUTY_W    = 4;
    localparam int DUTY_INIT = 5;
    localparam int RAMP_DIV  = 4;
    localparam int PWM_STEPS = 10;

    localparam int M_OFF  = 0;
    localparam int M_SOFT = 1;
    localparam int M_RUN  = 2;
    localparam int M_RAMP = 3;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              period_start = 1'b0;
    logic              inc_req = 1'b0;
    logic              dec_req = 1'b0;
    logic              target_valid = 1'b0;
    logic [DUTY_W-1:0] target_duty = '0;
    logic              target_ready;
    logic [DUTY_W-1:0] duty;
    logic              duty_update;
    logic              busy;
    logic              req_dropped;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   ps_phase = 0;
    logic cur_en = 1'b0;

    // Reference model state
    int m_mode, m_duty, m_pend, m_tgt, m_pulses;
    bit m_initp;
    exp_t upd_q[$];
    int   drop_q[$];

    pwm_duty_sequencer #(
        .PERIOD   (PERIOD),
        .DUTY_W   (DUTY_W),
        .DUTY_INIT(DUTY_INIT),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .period_start(period_start),
        .inc_req     (inc_req),
        .dec_req     (dec_req),
        .target_valid(target_valid),
        .target_duty (target_duty),
        .target_ready(target_ready),
        .duty        (duty),
        .duty_update (duty_update),
        .busy        (busy),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    task automatic resetModel();
        m_mode   = M_OFF;
        m_duty   = 0;
        m_pend   = 0;
        m_tgt    = 0;
        m_pulses = 0;
        m_initp  = 0;
        upd_q.delete();
        drop_q.delete();
    endtask

    // One clock of channel behaviour: boundaries are counted while ramping,
    // duty moves by one per RAMP_DIV counted boundaries, manual steps wait
    // for the next boundary, targets are clamped and approached stepwise.
    task automatic modelStep(input int nxt);
        int  old;
        int  t;
        bit  ready;
        old   = m_duty;
        ready = (m_mode == M_RUN) && !m_initp;
        if ((inc_req || dec_req) && m_mode != M_RUN) drop_q.push_back(nxt);
        if (!en) begin
            m_mode  = M_OFF;
            m_duty  = 0;
            m_pend  = 0;
            m_initp = 0;
        end else begin
            case (m_mode)
                M_OFF: begin
`ifdef PWM_SOFT_START_EN
                    m_mode   = M_SOFT;
                    m_pulses = 0;
`else
                    m_mode  = M_RUN;
                    m_initp = 1;
`endif
                end
                M_SOFT: begin
                    if (period_start) begin
                        m_pulses++;
                        if (m_pulses == RAMP_DIV) begin
                            m_pulses = 0;
                            m_duty++;
                            if (m_duty == DUTY_INIT) m_mode = M_RUN;
                        end
                    end
                end
                M_RAMP: begin
                    if (period_start) begin
                        m_pulses++;
                        if (m_pulses == RAMP_DIV) begin
                            m_pulses = 0;
                            m_duty += (m_tgt > m_duty) ? 1 : -1;
                            if (m_duty == m_tgt) m_mode = M_RUN;
                        end
                    end
                end
                default: begin
                    t = (int'(target_duty) > PERIOD) ? PERIOD : int'(target_duty);
                    if (target_valid && ready && t != m_duty) begin
                        m_mode   = M_RAMP;
                        m_tgt    = t;
                        m_pulses = 0;
                        m_pend   = 0;
                    end else begin
                        if (period_start) begin
                            if (m_initp) begin
                                m_duty  = DUTY_INIT;
                                m_initp = 0;
                            end else if (m_pend > 0 && m_duty < PERIOD) begin
                                m_duty++;
                            end else if (m_pend < 0 && m_duty > 0) begin
                                m_duty--;
                            end
                            m_pend = 0;
                        end
                        if (inc_req && dec_req) m_pend = 0;
                        else if (inc_req)       m_pend = 1;
                        else if (dec_req)       m_pend = -1;
                    end
                end
            endcase
        end
        if (m_duty != old) upd_q.push_back('{nxt, m_duty});
    endtask

    // Drive one cycle of inputs; period_start follows a 10-step PWM counter.
    task automatic applyStimulus(input logic e, input logic inc, input logic dec,
                                 input logic tv, input int td);
        int nxt;
        en           = e;
        inc_req      = inc;
        dec_req      = dec;
        target_valid = tv;
        target_duty  = DUTY_W'(td);
        period_start = (ps_phase == PWM_STEPS - 1);
        ps_phase     = (ps_phase + 1) % PWM_STEPS;
        nxt          = edge_cnt + 1;
        @(posedge clk);
        if (rst_n) modelStep(nxt);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(cur_en, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic manualReq(input logic inc, input logic dec);
        if (ps_phase == PWM_STEPS - 1) idle(1);
        applyStimulus(cur_en, inc, dec, 1'b0, 0);
        idle(PWM_STEPS);
    endtask

    task automatic offerTarget(input int t);
        applyStimulus(cur_en, 1'b0, 1'b0, 1'b1, t);
    endtask

    task automatic waitReady(input string what, input int budget);
        int n;
        n = 0;
        while (!target_ready && n < budget) begin
            idle(1);
            n++;
        end
        if (!target_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout %s: target_ready %0d, required 1 within %0d cycles", what, target_ready, budget);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " duty"}, int'(duty), 0);
        checkOutput({tag, " duty_update"}, int'(duty_update), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " target_ready"}, int'(target_ready), 0);
        checkOutput({tag, " req_dropped"}, int'(req_dropped), 0);
    endtask

    // Asynchronous reset asserted in the middle of a cycle.
    task automatic resetPulse();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("async reset");
        resetModel();
        cur_en       = 1'b0;
        en           = 1'b0;
        inc_req      = 1'b0;
        dec_req      = 1'b0;
        target_valid = 1'b0;
        period_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops predictions whenever the DUT pulses, flags predictions
    // whose edge has passed without a pulse, and tracks steady outputs.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (rst_n) begin
            if (duty_update) begin
                if (upd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious duty_update: duty %0d, no update expected (edge %0d)", duty, edge_cnt);
                end else begin
                    e = upd_q.pop_front();
                    checkOutput("duty_update edge", edge_cnt, e.cyc);
                    checkOutput("updated duty", int'(duty), e.val);
                end
            end else if (upd_q.size() > 0 && upd_q[0].cyc <= edge_cnt) begin
                e = upd_q.pop_front();
                checkOutput("missing duty_update", int'(duty_update), 1);
            end
            if (req_dropped) begin
                if (drop_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious req_dropped: got 1, expected 0 (edge %0d)", edge_cnt);
                end else begin
                    d = drop_q.pop_front();
                    checkOutput("req_dropped edge", edge_cnt, d);
                end
            end else if (drop_q.size() > 0 && drop_q[0] <= edge_cnt) begin
                d = drop_q.pop_front();
                checkOutput("missing req_dropped", int'(req_dropped), 1);
            end
            checkOutput("duty level", int'(duty), m_duty);
            checkOutput("busy level", int'(busy), int'(m_mode == M_SOFT || m_mode == M_RAMP));
            checkOutput("target_ready level", int'(target_ready), int'(m_mode == M_RUN && !m_initp));
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        idle(3);

        // Request while disabled is discarded
        manualReq(1'b1, 1'b0);

        // Enable: soft start (or direct init load) to DUTY_INIT
        cur_en = 1'b1;
        waitReady("startup", 400);
        checkOutput("startup duty", int'(duty), DUTY_INIT);
        checkOutput("startup busy", int'(busy), 0);

        // Step up to full scale, then saturate
        repeat (PERIOD - DUTY_INIT) manualReq(1'b1, 1'b0);
        checkOutput("full scale duty", int'(duty), PERIOD);
        manualReq(1'b1, 1'b0);
        checkOutput("saturated inc", int'(duty), PERIOD);
        manualReq(1'b0, 1'b1);
        checkOutput("dec from full", int'(duty), PERIOD - 1);

        // Later request overwrites: inc then dec -> net -1
        while (ps_phase >= PWM_STEPS - 2) idle(1);
        applyStimulus(cur_en, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(cur_en, 1'b0, 1'b1, 1'b0, 0);
        idle(PWM_STEPS);
        checkOutput("inc then dec", int'(duty), PERIOD - 2);
        manualReq(1'b1, 1'b1);
        checkOutput("inc and dec together", int'(duty), PERIOD - 2);

        // Target 2 with a dropped request during the ramp
        offerTarget(2);
        idle(5);
        checkOutput("ramp ready low", int'(target_ready), 0);
        manualReq(1'b1, 1'b0);
        waitReady("ramp to 2", 600);
        checkOutput("ramp end duty", int'(duty), 2);

        // Over-range target is clamped
        offerTarget(15);
        waitReady("ramp to clamp", 600);
        checkOutput("clamped duty", int'(duty), PERIOD);

        // Target equal to duty: no ramp
        offerTarget(PERIOD);
        idle(2 * PWM_STEPS);
        checkOutput("equal target busy", int'(busy), 0);
        checkOutput("equal target duty", int'(duty), PERIOD);

        // Enable dropped mid-ramp
        offerTarget(3);
        idle(45);
        cur_en = 1'b0;
        idle(1);
        checkOutput("disable duty", int'(duty), 0);
        idle(3);
        cur_en = 1'b1;
        waitReady("re-enable", 400);

        // Reset asserted mid-ramp
        offerTarget(0);
        idle(25);
        resetPulse();
        idle(3);
        cur_en = 1'b1;
        waitReady("after reset", 400);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic inc, dec, tv;
            int   td;
            if (cur_en) begin
                if ($urandom_range(0, 199) == 0) cur_en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                cur_en = 1'b1;
            end
            inc = ($urandom_range(0, 19) == 0);
            dec = ($urandom_range(0, 19) == 0);
            tv  = ($urandom_range(0, 29) == 0);
            td  = int'($urandom_range(0, 15));
            applyStimulus(cur_en, inc, dec, tv, td);
        end
        idle(3);

        checkOutput("leftover duty updates", upd_q.size(), 0);
        checkOutput("leftover dropped requests", drop_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
